// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the clkgen test-clock generator.
// Optional feature macro: CLKGEN_EDGE_CNT_EN (see clkgen.sv).
package clkgen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    // Accumulator width able to hold acc + 2*f without overflow.
    function automatic int acc_w(input int clk_mhz);
        return $clog2(32'sd2 * clk_mhz) + 32'sd1;
    endfunction

    // A frequency is legal when the output toggles at most once per clk cycle.
    function automatic logic freq_ok(input int f, input int clk_mhz);
        return (f >= 32'sd1) && (f <= clk_mhz / 32'sd2);
    endfunction

endpackage

// File: rtl/clkgen_nco.sv
// Phase accumulator (NCO) modulo CLK_MHZ plus the registered tst_clk output.
// rise/fall flag, in the current cycle, that the coming edge toggles tst_clk.
module clkgen_nco
    import clkgen_pkg::*;
#(
    parameter int CLK_MHZ = 100,
    parameter int ACC_W   = acc_w(CLK_MHZ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] step,
    input  logic             advance,
    input  logic             clear,
    output logic             tst_clk,
    output logic             rise,
    output logic             fall
);

    localparam logic [ACC_W-1:0] MODULUS = ACC_W'(CLK_MHZ);

    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nx_s;
    logic [ACC_W-1:0] sum_s;
    logic             wrap_s;
    logic             tst_clk_r;
    logic             tst_nx_s;

    // Next phase and toggle decision; clear wins over accumulation for acc only,
    // so a falling toggle still completes when acc is cleared on the same edge.
    always_comb begin
        sum_s  = acc_r + step;
        wrap_s = advance && (sum_s >= MODULUS);
        if (clear) begin
            acc_nx_s = '0;
        end else if (advance) begin
            acc_nx_s = wrap_s ? (sum_s - MODULUS) : sum_s;
        end else begin
            acc_nx_s = acc_r;
        end
        if (advance) begin
            tst_nx_s = tst_clk_r ^ wrap_s;
        end else if (clear) begin
            tst_nx_s = 1'b0;
        end else begin
            tst_nx_s = tst_clk_r;
        end
        rise = wrap_s & ~tst_clk_r;
        fall = wrap_s & tst_clk_r;
    end

    // Accumulator and output clock registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= '0;
            tst_clk_r <= 1'b0;
        end else begin
            acc_r     <= acc_nx_s;
            tst_clk_r <= tst_nx_s;
        end
    end

    assign tst_clk = tst_clk_r;

endmodule

// File: rtl/clkgen.sv
// Programmable integer-MHz test clock generator: FSM and frequency request handshake.
// Define CLKGEN_EDGE_CNT_EN to add the edge_cnt rising-edge counter output.
module clkgen
    import clkgen_pkg::*;
#(
    parameter int CLK_MHZ = 100,
    parameter int TST_MHZ = 30,
    parameter int FREQ_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [FREQ_W-1:0] freq,
    input  logic              freq_valid,
    output logic              freq_ready,
    output logic              freq_err,
    output logic              tst_clk,
    output logic              running
`ifdef CLKGEN_EDGE_CNT_EN
    ,
    output logic [31:0]       edge_cnt
`endif
);

    localparam int ACC_W = acc_w(CLK_MHZ);

    if (!freq_ok(TST_MHZ, CLK_MHZ)) begin : g_bad_tst_mhz
        $error("clkgen: TST_MHZ must lie in 1..CLK_MHZ/2");
    end

    state_t            state_r;
    state_t            state_nx_s;
    logic              running_r;
    logic [FREQ_W-1:0] f_r;
    logic [FREQ_W-1:0] pend_r;
    logic              freq_ready_r;
    logic              freq_err_r;
    logic              advance_s;
    logic              fsm_clear_s;
    logic              clear_s;
    logic              accept_s;
    logic              req_ok_s;
    logic              apply_s;
    logic              rise_s;
    logic              fall_s;
    logic              tst_clk_s;
    logic [ACC_W-1:0]  step_s;

    assign advance_s = (state_r == RUN) || (state_r == STOP);
    assign step_s    = ACC_W'({f_r, 1'b0});
    assign accept_s  = freq_valid && freq_ready_r;
    assign req_ok_s  = freq_ok(32'(freq), CLK_MHZ);
    // A pending request exists exactly while freq_ready is low.
    assign apply_s   = !freq_ready_r && ((state_r == IDLE) || fall_s);
    assign clear_s   = fsm_clear_s || apply_s;

    clkgen_nco #(
        .CLK_MHZ (CLK_MHZ),
        .ACC_W   (ACC_W)
    ) u_nco (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (step_s),
        .advance (advance_s),
        .clear   (clear_s),
        .tst_clk (tst_clk_s),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    // Next-state logic; stopping only ever completes on a low output
    always_comb begin
        state_nx_s  = state_r;
        fsm_clear_s = 1'b0;
        case (state_r)
            IDLE: begin
                fsm_clear_s = 1'b1;
                if (en) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (en) begin
                    state_nx_s = RUN;
                end else if (!tst_clk_s && !rise_s) begin
                    state_nx_s  = IDLE;
                    fsm_clear_s = 1'b1;
                end else begin
                    state_nx_s = STOP;
                end
            end
            STOP: begin
                if (en) begin
                    state_nx_s = RUN;
                end else if (fall_s) begin
                    state_nx_s  = IDLE;
                    fsm_clear_s = 1'b1;
                end else begin
                    state_nx_s = STOP;
                end
            end
            default: begin
                state_nx_s  = IDLE;
                fsm_clear_s = 1'b1;
            end
        endcase
    end

    // State register with registered running flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            running_r <= (state_nx_s != IDLE);
        end
    end

    // Frequency request handshake and active frequency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_r          <= FREQ_W'(TST_MHZ);
            pend_r       <= '0;
            freq_ready_r <= 1'b1;
            freq_err_r   <= 1'b0;
        end else begin
            freq_err_r <= accept_s && !req_ok_s;
            if (apply_s) begin
                f_r          <= pend_r;
                freq_ready_r <= 1'b1;
            end else if (accept_s && req_ok_s) begin
                pend_r       <= freq;
                freq_ready_r <= 1'b0;
            end else begin
                freq_ready_r <= freq_ready_r;
            end
        end
    end

    assign freq_ready = freq_ready_r;
    assign freq_err   = freq_err_r;
    assign tst_clk    = tst_clk_s;
    assign running    = running_r;

`ifdef CLKGEN_EDGE_CNT_EN
    logic [31:0] edge_cnt_r;

    // Rising-edge counter, restarted on each IDLE->RUN transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_r <= 32'd0;
        end else if ((state_r == IDLE) && (state_nx_s == RUN)) begin
            edge_cnt_r <= 32'd0;
        end else if (rise_s) begin
            edge_cnt_r <= edge_cnt_r + 32'd1;
        end else begin
            edge_cnt_r <= edge_cnt_r;
        end
    end

    assign edge_cnt = edge_cnt_r;
`endif

endmodule

// File: tb/tb_clkgen.sv
// Directed-vector bench for clkgen at the default 100/30 MHz configuration.
module tb_clkgen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] freq;
    logic        freq_valid;
    logic        freq_ready;
    logic        freq_err;
    logic        tst_clk;
    logic        running;
`ifdef CLKGEN_EDGE_CNT_EN
    logic [31:0] edge_cnt;
`endif

    always #5 clk = ~clk;

    clkgen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .freq       (freq),
        .freq_valid (freq_valid),
        .freq_ready (freq_ready),
        .freq_err   (freq_err),
        .tst_clk    (tst_clk),
        .running    (running)
`ifdef CLKGEN_EDGE_CNT_EN
        ,
        .edge_cnt   (edge_cnt)
`endif
    );

    typedef struct {
        logic        en;
        logic        fv;
        logic [15:0] freq;
        logic        tst;
        logic        run;
        logic        rdy;
        logic        err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic add(input logic e, input logic v, input int f,
                       input logic t, input logic r, input logic y, input logic x);
        vec_t tmp;
        tmp.en = e; tmp.fv = v; tmp.freq = 16'(f);
        tmp.tst = t; tmp.run = r; tmp.rdy = y; tmp.err = x;
        vecs.push_back(tmp);
    endtask

    initial begin
        int cnt;
        int first_rise;
        int wait_cyc;
        logic prev;

        rst_n = 1'b0; en = 1'b0; freq_valid = 1'b0; freq = 16'd0;

        //  en v  freq tst run rdy err
        add(0, 0,  0,  0,  0,  1,  0);   // v0 idle
        add(1, 0,  0,  0,  1,  1,  0);   // v1 IDLE->RUN
        add(1, 0,  0,  0,  1,  1,  0);   // v2 acc 60
        add(1, 0,  0,  1,  1,  1,  0);   // v3 first rise (2nd RUN cycle)
        add(1, 0,  0,  1,  1,  1,  0);   // v4 acc 80
        add(1, 0,  0,  0,  1,  1,  0);   // v5 fall
        add(1, 0,  0,  1,  1,  1,  0);   // v6 rise, acc 0
        add(0, 0,  0,  1,  1,  1,  0);   // v7 en drop while high -> STOP
        add(0, 0,  0,  0,  0,  1,  0);   // v8 fall -> IDLE
        add(0, 0,  0,  0,  0,  1,  0);   // v9
        add(1, 0,  0,  0,  1,  1,  0);   // v10 -> RUN
        add(0, 0,  0,  0,  0,  1,  0);   // v11 low, no toggle -> IDLE directly
        add(0, 0,  0,  0,  0,  1,  0);   // v12
        add(1, 0,  0,  0,  1,  1,  0);   // v13 -> RUN
        add(1, 0,  0,  0,  1,  1,  0);   // v14 acc 60
        add(1, 0,  0,  1,  1,  1,  0);   // v15 rise, acc 20
        add(0, 0,  0,  1,  1,  1,  0);   // v16 STOP, acc 80
        add(1, 0,  0,  0,  1,  1,  0);   // v17 back to RUN, fall, acc 40
        add(1, 0,  0,  1,  1,  1,  0);   // v18 rise proves phase kept
        add(1, 0,  0,  1,  1,  1,  0);   // v19 acc 60
        add(1, 0,  0,  0,  1,  1,  0);   // v20 fall, acc 20
        add(1, 1,  0,  0,  1,  1,  1);   // v21 freq=0 rejected
        add(1, 0,  0,  1,  1,  1,  0);   // v22 err is one cycle
        add(1, 1, 51,  0,  1,  1,  1);   // v23 freq=51 rejected
        add(1, 0,  0,  0,  1,  1,  0);   // v24 acc 60
        add(1, 1, 50,  1,  1,  0,  0);   // v25 freq=50 accepted
        add(1, 1,  0,  1,  1,  0,  0);   // v26 ignored while not ready
        add(1, 0,  0,  0,  1,  1,  0);   // v27 apply on fall
        add(1, 0,  0,  1,  1,  1,  0);   // v28 clk/2
        add(1, 0,  0,  0,  1,  1,  0);   // v29
        add(1, 0,  0,  1,  1,  1,  0);   // v30
        add(1, 0,  0,  0,  1,  1,  0);   // v31
        add(0, 1, 30,  1,  1,  0,  0);   // v32 accept + en drop, rise -> STOP
        add(0, 0,  0,  0,  0,  1,  0);   // v33 apply and stop on same fall
        add(1, 0,  0,  0,  1,  1,  0);   // v34 -> RUN
        add(1, 0,  0,  0,  1,  1,  0);   // v35 acc 60 (30 MHz again)
        add(1, 0,  0,  1,  1,  1,  0);   // v36 rise, acc 20
        add(0, 0,  0,  1,  1,  1,  0);   // v37 STOP, acc 80
        add(0, 0,  0,  0,  0,  1,  0);   // v38 fall -> IDLE
        add(0, 1, 50,  0,  0,  0,  0);   // v39 accept in IDLE
        add(0, 0,  0,  0,  0,  1,  0);   // v40 applied next cycle
        add(1, 0,  0,  0,  1,  1,  0);   // v41 -> RUN
        add(1, 0,  0,  1,  1,  1,  0);   // v42 rise after 1 RUN cycle at 50
        add(1, 0,  0,  0,  1,  1,  0);   // v43
        add(1, 1, 10,  1,  1,  0,  0);   // v44 pending 10, high phase

        repeat (2) @(posedge clk);
        #1;
        chk("reset tst_clk", int'(tst_clk), 0);
        chk("reset running", int'(running), 0);
        chk("reset freq_ready", int'(freq_ready), 1);
        chk("reset freq_err", int'(freq_err), 0);
`ifdef CLKGEN_EDGE_CNT_EN
        chk("reset edge_cnt", int'(edge_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            en = vecs[i].en; freq_valid = vecs[i].fv; freq = vecs[i].freq;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d tst_clk", i), int'(tst_clk), int'(vecs[i].tst));
            chk($sformatf("v%0d running", i), int'(running), int'(vecs[i].run));
            chk($sformatf("v%0d freq_ready", i), int'(freq_ready), int'(vecs[i].rdy));
            chk($sformatf("v%0d freq_err", i), int'(freq_err), int'(vecs[i].err));
        end

        // Asynchronous reset in the middle of a high phase, with a request pending
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst tst_clk", int'(tst_clk), 0);
        chk("async rst running", int'(running), 0);
        chk("async rst freq_ready", int'(freq_ready), 1);
        @(negedge clk);
        en = 1'b0; freq_valid = 1'b0; freq = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;

        // Back at 30 MHz: first rise 2 RUN cycles in, 3000 +-1 rises in 10000 cycles
        cnt = 0;
        first_rise = 0;
        prev = 1'b0;
        for (int k = 1; k <= 10000; k++) begin
            @(posedge clk);
            #1;
            if (tst_clk && !prev) begin
                cnt++;
                if (first_rise == 0) first_rise = k;
            end
            prev = tst_clk;
        end
        chk("first rise cycle", first_rise, 3);
        chk_range("rise count 10000 cyc", cnt, 2999, 3001);
        chk("running after count", int'(running), 1);
`ifdef CLKGEN_EDGE_CNT_EN
        chk_range("edge_cnt range", int'(edge_cnt), 2999, 3001);
        chk("edge_cnt vs observed", int'(edge_cnt), cnt);
`endif

        // Stop, then restart
        @(negedge clk);
        en = 1'b0;
        wait_cyc = 0;
        while (running && wait_cyc < 20) begin
            @(posedge clk);
            #1;
            if (tst_clk && !prev) cnt++;
            prev = tst_clk;
            wait_cyc++;
        end
        chk("stop within bound", int'(wait_cyc < 20), 1);
        chk("stopped tst_clk", int'(tst_clk), 0);
        @(posedge clk);
        #1;
        chk("idle running", int'(running), 0);
`ifdef CLKGEN_EDGE_CNT_EN
        chk("edge_cnt held in IDLE", int'(edge_cnt), cnt);
`endif
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("restart running", int'(running), 1);
`ifdef CLKGEN_EDGE_CNT_EN
        chk("edge_cnt cleared on restart", int'(edge_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkgen.md
Name: clkgen

Overview:
- Generates a test clock `tst_clk` of a programmable integer-MHz frequency from the system clock. Uses a fractional phase accumulator (NCO).
- Drive end of the clock-monitoring path: its output feeds monitor blocks and benches as a known-frequency source.
- Output is a plain register, so it is glitch-free.
- Start, stop and frequency changes take effect only at clean edges.

Parameters:
- CLK_MHZ, 100: system clock frequency in MHz; denominator of the accumulator.
- TST_MHZ, 30: reset-time output frequency in MHz. Must satisfy 1 <= TST_MHZ <= CLK_MHZ/2 (elaboration-time check).
- FREQ_W, 16: width of the runtime frequency request.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: level; high requests output running.
- freq, input, FREQ_W: requested output frequency in MHz.
- freq_valid, input, 1: frequency request strobe.
- freq_ready, output, 1: high when a new request can be accepted.
- freq_err, output, 1: one-cycle pulse when a request is rejected.
- tst_clk, output, 1: generated clock (registered).
- running, output, 1: high when state != IDLE.

Behaviour:
- Reset values:
  - state IDLE, acc 0, tst_clk 0, running 0.
  - freq_ready 1, freq_err 0.
  - active frequency f = TST_MHZ; no pending request.
- Accumulator:
  - Width ACC_W = $clog2(2*CLK_MHZ)+1; acc is always in [0, CLK_MHZ).
  - In RUN or STOP, each cycle computes sum = acc + 2*f.
  - If sum >= CLK_MHZ: acc <= sum - CLK_MHZ and tst_clk toggles. Otherwise acc <= sum.
  - At most one toggle per cycle. Long-term output frequency = f exactly.
  - f = CLK_MHZ/2 gives clk/2.
- States:
  - IDLE: tst_clk 0, acc 0. en=1 -> RUN next cycle.
  - RUN: accumulate/toggle. en=0 -> STOP, or directly IDLE if tst_clk is 0 in that cycle and no toggle occurs.
  - STOP: keep accumulating. On the 1->0 toggle -> IDLE, with acc cleared.
    - en re-asserted in STOP -> RUN, no interruption of phase.
- Start latency:
  - First rising edge of tst_clk occurs in RUN cycle ceil(CLK_MHZ/(2f)).
  - Example: 100/30 gives sums 60, 120 -> rising edge after the 2nd RUN cycle.
- Frequency request:
  - Accepted on freq_valid & freq_ready.
  - Valid range is 1 <= freq <= CLK_MHZ/2.
  - Out-of-range request: freq_err pulses the next cycle, the request is discarded, freq_ready stays 1.
  - In-range request: stored as pending, freq_ready <= 0.
  - Apply point:
    - in IDLE: the cycle after acceptance;
    - in RUN/STOP: the cycle of the next 1->0 toggle.
  - At the apply point: f <= pending, acc <= 0, freq_ready <= 1.
  - freq_valid while freq_ready=0 is ignored, with no error.
- Simultaneous events:
  - Apply and stop on the same falling toggle: both occur; IDLE with the new f.
  - en falling in the same cycle as acceptance: acceptance proceeds normally.
- Reset mid-operation: tst_clk drops to 0 asynchronously; any pending request is lost.

Optional Feature:
- Macro: CLKGEN_EDGE_CNT_EN.
- Defined: adds output edge_cnt [31:0], a count of tst_clk rising edges.
  - Reset 0; wraps at 2^32.
  - Cleared on the IDLE->RUN transition.
  - Held (not cleared) in STOP and IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package clkgen_pkg:
  - state enum {IDLE, RUN, STOP};
  - function acc_w(clk_mhz);
  - function freq_ok(f, clk_mhz).
- Sub-module clkgen_nco:
  - holds the accumulator and tst_clk register;
  - inputs: step (2*f), advance, clear;
  - outputs: tst_clk, a rise pulse and a fall pulse.
- Top-level owns the FSM and the request handshake.

Test Plan:
- Defaults 100/30, en high after reset: first tst_clk rise 2 cycles after RUN entry; 30000 ± 1 rising edges in 1 ms of clk; running=1.
- freq=50 request while running: applied at the next falling edge; tst_clk then toggles every clk cycle (period 20 ns); freq_ready low until apply, then high.
- freq=0, then freq=51: each gives a freq_err one-cycle pulse; f unchanged (edge period still 33.3 ns average); freq_ready stays 1.
- en dropped while tst_clk=1: tst_clk completes its high phase, falls, state -> IDLE; running=0 the cycle after; tst_clk never glitches (no high pulse shorter than 1 clk).
- Async rst_n asserted mid-high phase: tst_clk=0 and running=0 immediately; a pending freq request is discarded; after release, frequency is back to 30 MHz.
- With CLKGEN_EDGE_CNT_EN: run for 1000 clk cycles at 30 MHz -> edge_cnt = 300 ± 1; stop/restart clears it to 0.
